// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter.
//   tx_state_e   : transmitter FSM state encoding (IDLE/START/DATA/STOP)
//   DATA_BITS    : payload bits per frame
//   FRAME_BITS   : start + data + stop bits per frame
//   clks_per_bit : clock cycles per bit for a given clock frequency and baud rate
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Integer division; the caller must choose parameters giving a result >= 2.
    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with show-ahead head output.
//   clk         : clock
//   reset       : asynchronous active-high reset (empties the FIFO)
//   push_i      : write request; ignored while full
//   push_data_i : data written on push
//   pop_i       : read request; ignored while empty
//   head_o      : oldest entry, valid whenever empty_o is low
//   full_o      : no free entry
//   empty_o     : no stored entry
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit: equal indices with differing MSBs means full.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with a small input FIFO.
//   clk      : clock
//   reset    : asynchronous active-high reset; forces txd high and flushes the FIFO
//   wr_data  : byte to transmit
//   wr_valid : write request, accepted when wr_ready is high
//   wr_ready : FIFO has room (not full)
//   busy     : FIFO non-empty or a frame in progress
//   txd      : registered serial output, idle high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       busy,
    output logic       txd
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    tx_state_e      state_q;
    logic [7:0]     shift_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic           txd_q;

    logic           baud_end;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_head;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (wr_valid),
        .push_data_i (wr_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign baud_end   = (baud_cnt_q == BAUD_LAST);
    assign baud_cnt_d = baud_end ? '0 : baud_cnt_q + CNT_W'(1);

    // Pop from IDLE, or at the end of a stop bit so frames run back to back.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));

    assign wr_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign txd      = txd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shift_q    <= fifo_head;
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= '0;
                        txd_q      <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    baud_cnt_q <= baud_cnt_d;
                    if (baud_end) begin
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    baud_cnt_q <= baud_cnt_d;
                    if (baud_end) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            // Drive the next bit directly so txd stays registered.
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    baud_cnt_q <= baud_cnt_d;
                    if (baud_end) begin
                        if (fifo_pop) begin
                            shift_q   <= fifo_head;
                            bit_cnt_q <= '0;
                            txd_q     <= 1'b0;
                            state_q   <= ST_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD_R = 100;
    localparam int DEPTH  = 4;
    localparam int CPB    = 10;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready;
    logic       busy;
    logic       txd;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    int         fall_q [$];

    // monitor state
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic       mon_prev   = 1'b1;
    logic [7:0] mon_rx     = 8'h00;
    logic [7:0] mon_exp    = 8'h00;

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .busy     (busy),
        .txd      (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d (0x%0h)", name, act, act);
        end
    endtask

    // Frame decoder / scoreboard: samples txd mid-bit on falling clock edges.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                mon_prev   = 1'b1;
            end else begin
                if (!mon_active) begin
                    if (mon_prev && !txd) begin
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                        fall_q.push_back(cyc);
                    end
                end else begin
                    mon_cnt++;
                end
                if (mon_active) begin
                    if (mon_cnt == CPB/2) begin
                        chk("start_bit", int'(txd), 0);
                    end else if (mon_cnt > CPB && mon_cnt < 9*CPB && (mon_cnt % CPB) == CPB/2) begin
                        mon_rx[mon_cnt/CPB - 1] = txd;
                    end else if (mon_cnt == 9*CPB + CPB/2) begin
                        chk("stop_bit", int'(txd), 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got 0x%02h expected no frame", mon_rx);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            chk("frame_byte", int'(mon_rx), int'(mon_exp));
                        end
                        mon_active = 1'b0;
                    end
                end
                mon_prev = txd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic write_byte(input logic [7:0] b, output int acc);
        wr_data  = b;
        wr_valid = 1'b1;
        tick();
        acc      = cyc;
        wr_valid = 1'b0;
    endtask

    // Returns the edge index after which busy was first seen low, or -1.
    task automatic wait_idle(output int drop);
        drop = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin
                drop = cyc;
                break;
            end
        end
        tick();
    endtask

    task automatic wait_falls(input int cnt);
        for (int i = 0; i < 50 && fall_q.size() < cnt; i++) tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, a, d, bt, bb, br;

        // asynchronous reset before the first clock edge
        #3 reset = 1'b1;
        #1;
        chk("rst_txd", int'(txd), 1);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // idle for 200 cycles
        bt = 0; bb = 0; br = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bt++;
            if (busy !== 1'b0) bb++;
            if (wr_ready !== 1'b1) br++;
        end
        tick();
        chk("idle_txd_bad_cycles", bt, 0);
        chk("idle_busy_bad_cycles", bb, 0);
        chk("idle_ready_bad_cycles", br, 0);

        // single byte 0xA5
        fall_q.delete();
        exp_q.push_back(8'hA5);
        write_byte(8'hA5, n);
        wait_falls(1);
        chk("a5_fall_edge", (fall_q.size() > 0) ? fall_q[0] : -1, n + 1);
        wait_idle(d);
        chk("a5_busy_drop_edge", d, n + 1 + 10*CPB);

        // burst 1..5 with valid held high, then write attempts while full
        fall_q.delete();
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        wr_valid = 1'b1;
        for (int b = 1; b <= 5; b++) begin
            chk("burst_ready", int'(wr_ready), 1);
            wr_data = 8'(b);
            tick();
            if (b == 1) n = cyc;
        end
        wr_valid = 1'b0;
        chk("burst_full_ready", int'(wr_ready), 0);
        wait_until(n + 50);
        wr_data  = 8'hFF;
        wr_valid = 1'b1;
        repeat (3) begin
            chk("full_write_ready", int'(wr_ready), 0);
            tick();
        end
        wr_valid = 1'b0;
        wait_until(n + 10*CPB);
        chk("ready_before_pop", int'(wr_ready), 0);
        tick();
        chk("ready_after_pop", int'(wr_ready), 1);
        wait_idle(d);
        chk("burst_busy_drop_edge", d, n + 1 + 50*CPB);
        chk("burst_frame_count", fall_q.size(), 5);
        for (int k = 0; k < fall_q.size() && k < 5; k++)
            chk("burst_fall_edge", fall_q[k], n + 1 + 10*CPB*k);

        // write coinciding with a stop-end pop, FIFO holding two entries
        fall_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        write_byte(8'h11, n);
        write_byte(8'h22, a);
        write_byte(8'h33, a);
        wait_until(n + 10*CPB);
        write_byte(8'h55, a);
        chk("same_cycle_write_edge", a, n + 1 + 10*CPB);
        chk("same_cycle_ready_occ2", int'(wr_ready), 1);
        write_byte(8'h66, a);
        chk("same_cycle_ready_occ3", int'(wr_ready), 1);
        write_byte(8'h77, a);
        chk("same_cycle_ready_occ4", int'(wr_ready), 0);
        wait_idle(d);
        chk("same_cycle_busy_drop_edge", d, n + 1 + 60*CPB);
        chk("same_cycle_frame_count", fall_q.size(), 6);
        for (int k = 0; k < fall_q.size() && k < 6; k++)
            chk("same_cycle_fall_edge", fall_q[k], n + 1 + 10*CPB*k);

        // asynchronous reset during data bit 3 of 0x00
        fall_q.delete();
        write_byte(8'h00, n);
        wait_until(n + 45);
        #2;
        chk("pre_reset_txd", int'(txd), 0);
        reset = 1'b1;
        #1;
        chk("async_reset_txd", int'(txd), 1);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_ready", int'(wr_ready), 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        bt = 0; bb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bt++;
            if (busy !== 1'b0) bb++;
        end
        tick();
        chk("post_reset_txd_bad_cycles", bt, 0);
        chk("post_reset_busy_bad_cycles", bb, 0);
        chk("post_reset_frames_started", fall_q.size(), 1);

        chk("expected_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
